line_write_buffer: RTL

//  Line-granular write buffer between the cache miss FSM and main memory.

---
 rtl/line_write_buffer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/line_write_buffer.sv
// Line-granular write buffer between the cache miss FSM and main memory.
// Optional flush port pair (flush_req/flush_busy) is built when WB_FLUSH_EN is defined.
module line_write_buffer #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 9,
    parameter int unsigned DEPTH_LEN     = 2,
    localparam int unsigned LINE_W       = 32 * (2 ** LINE_ADDR_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_LEN-1:0]  up_addr,
    input  logic                 up_rd_req,
    input  logic                 up_wr_req,
    input  logic [LINE_W-1:0]    up_wr_line,
    output logic [LINE_W-1:0]    up_rd_line,
    output logic                 up_gnt,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic                 mem_rd_req,
    output logic                 mem_wr_req,
    output logic [LINE_W-1:0]    mem_wr_line,
    input  logic [LINE_W-1:0]    mem_rd_line,
    input  logic                 mem_gnt,
    output logic [DEPTH_LEN:0]   wb_count,
`ifdef WB_FLUSH_EN
    input  logic                 flush_req,
    output logic                 flush_busy,
`endif
    output logic                 wb_full
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LEN;
    localparam logic [DEPTH_LEN:0] FULL_CNT = {1'b1, {DEPTH_LEN{1'b0}}};

    typedef enum logic {U_IDLE, U_ACK} u_state_t;
    typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN} m_state_t;

    u_state_t u_state_q, u_state_d;
    m_state_t m_state_q, m_state_d;

    logic [ADDR_LEN-1:0]  addr_q  [DEPTH];
    logic [LINE_W-1:0]    line_q  [DEPTH];
    logic                 valid_q [DEPTH];
    logic [DEPTH_LEN-1:0] head_q, head_d;
    logic [DEPTH_LEN-1:0] tail_q, tail_d;
    logic [DEPTH_LEN:0]   count_q, count_d;
    logic [LINE_W-1:0]    up_rd_line_q;
    logic [ADDR_LEN-1:0]  rd_addr_q;

    logic                 match_any;
    logic [DEPTH_LEN-1:0] match_idx;
    logic                 full;
    logic                 flush_on;
    logic                 idle_ok;
    logic                 head_busy;
    logic                 rd_hit, rd_miss, rd_done;
    logic                 wr_push, wr_coalesce;
    logic                 do_pop;

`ifdef WB_FLUSH_EN
    assign flush_on   = flush_req;
    assign flush_busy = flush_req && (count_q != '0);
`else
    assign flush_on   = 1'b0;
`endif

    assign full     = (count_q == FULL_CNT);
    assign wb_full  = full;
    assign wb_count = count_q;
    assign up_rd_line = up_rd_line_q;

    // At most one valid entry can hold a given address, so the last hit wins trivially.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == up_addr)) begin
                match_any = 1'b1;
                match_idx = DEPTH_LEN'(i);
            end
        end
    end

    // ---------------- upstream FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) u_state_q <= U_IDLE;
        else     u_state_q <= u_state_d;
    end

    always_comb begin
        u_state_d = u_state_q;
        unique case (u_state_q)
            U_IDLE: if (rd_hit || rd_done || wr_push || wr_coalesce) u_state_d = U_ACK;
            U_ACK:  u_state_d = U_IDLE;
        endcase
    end

    // A write that hits the head while it is in flight stalls; once popped it no longer matches and pushes.
    always_comb begin
        idle_ok     = (u_state_q == U_IDLE) && !flush_on;
        head_busy   = match_any && (match_idx == head_q) && (m_state_q == M_DRAIN);
        rd_hit      = idle_ok && up_rd_req && match_any;
        rd_miss     = idle_ok && up_rd_req && !match_any;
        rd_done     = (u_state_q == U_IDLE) && up_rd_req && (m_state_q == M_READ) && mem_gnt;
        wr_coalesce = idle_ok && !up_rd_req && up_wr_req && match_any && !head_busy;
        wr_push     = idle_ok && !up_rd_req && up_wr_req && !match_any && !full;
        up_gnt      = (u_state_q == U_ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_rd_line_q <= '0;
        end else if (rd_hit) begin
            up_rd_line_q <= line_q[match_idx];
        end else if (rd_done) begin
            up_rd_line_q <= mem_rd_line;
        end
    end

    // ---------------- memory FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_state_q <= M_IDLE;
        else     m_state_q <= m_state_d;
    end

    always_comb begin
        m_state_d = m_state_q;
        unique case (m_state_q)
            M_IDLE: begin
                if (rd_miss)              m_state_d = M_READ;
                else if (count_q != '0)   m_state_d = M_DRAIN;
            end
            M_READ:  if (mem_gnt) m_state_d = M_IDLE;
            M_DRAIN: if (mem_gnt) m_state_d = M_IDLE;
            default: m_state_d = M_IDLE;
        endcase
    end

    // Drain data is read straight from the head slot; the head cannot be rewritten while it drains.
    always_comb begin
        mem_rd_req  = (m_state_q == M_READ);
        mem_wr_req  = (m_state_q == M_DRAIN);
        do_pop      = (m_state_q == M_DRAIN) && mem_gnt;
        mem_addr    = '0;
        mem_wr_line = '0;
        if (m_state_q == M_READ) begin
            mem_addr = rd_addr_q;
        end else if (m_state_q == M_DRAIN) begin
            mem_addr    = addr_q[head_q];
            mem_wr_line = line_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if ((m_state_q == M_IDLE) && rd_miss) begin
            rd_addr_q <= up_addr;
        end
    end

    // ---------------- entry storage ----------------
    always_comb begin
        head_d  = do_pop  ? head_q + DEPTH_LEN'(1) : head_q;
        tail_d  = wr_push ? tail_q + DEPTH_LEN'(1) : tail_q;
        count_d = count_q + (DEPTH_LEN+1)'(wr_push) - (DEPTH_LEN+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                line_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (wr_push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= up_addr;
                line_q[tail_q]  <= up_wr_line;
            end
            if (wr_coalesce) begin
                line_q[match_idx] <= up_wr_line;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
